// File: rtl/div_unit_pkg.sv
// Shared encodings for the RV32M divider: funct3 codes, M-extension opcode
// fields and the divider FSM states.
package div_unit_pkg;

    localparam logic [6:0] INST_TYPE_M = 7'b0110011;
    localparam logic [6:0] FUNCT7_M    = 7'b0000001;

    localparam logic [2:0] INST_DIV  = 3'b100;
    localparam logic [2:0] INST_DIVU = 3'b101;
    localparam logic [2:0] INST_REM  = 3'b110;
    localparam logic [2:0] INST_REMU = 3'b111;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    function automatic logic is_signed_op(input logic [2:0] funct3);
        return (funct3 == INST_DIV) || (funct3 == INST_REM);
    endfunction

    function automatic logic is_rem_op(input logic [2:0] funct3);
        return (funct3 == INST_REM) || (funct3 == INST_REMU);
    endfunction

endpackage

// File: rtl/div_unit.sv
// Multi-cycle restoring divider for DIV/DIVU/REM/REMU, one quotient bit per
// cycle on operand magnitudes, with sign correction applied on completion.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [2:0]            funct3_i,
    input  logic [DATA_WIDTH-1:0] dividend_i,
    input  logic [DATA_WIDTH-1:0] divisor_i,
    input  logic [4:0]            rd_addr_i,
    input  logic                  flush_i,
    output logic                  busy_o,
    output logic [DATA_WIDTH-1:0] result_o,
    output logic                  result_valid_o,
    output logic [4:0]            rd_addr_o
);

    localparam logic [CNT_WIDTH-1:0] LAST_ITER = CNT_WIDTH'(DATA_WIDTH - 1);

    div_state_e            state;
    logic [CNT_WIDTH-1:0]  counter;
    logic [DATA_WIDTH-1:0] quot_r;
    logic [DATA_WIDTH-1:0] rem_r;
    logic [DATA_WIDTH-1:0] divisor_r;
    logic [4:0]            rd_r;
    logic                  rem_sel_r;
    logic                  div0_r;
    logic                  neg_q_r;
    logic                  neg_r_r;

    logic                  accept;
    logic                  op_signed;
    logic                  dividend_neg;
    logic                  divisor_neg;
    logic [DATA_WIDTH-1:0] dividend_mag;
    logic [DATA_WIDTH-1:0] divisor_mag;
    logic [DATA_WIDTH:0]   rem_shift;
    logic [DATA_WIDTH:0]   rem_diff;
    logic [DATA_WIDTH-1:0] rem_next;
    logic [DATA_WIDTH-1:0] quot_next;
    logic [DATA_WIDTH-1:0] quot_fix;
    logic [DATA_WIDTH-1:0] rem_fix;
    logic [DATA_WIDTH-1:0] result_next;

    assign accept = (state == DIV_IDLE) && start_i && funct3_i[2] && !flush_i;
    assign busy_o = start_i || (state != DIV_IDLE);

    always_comb begin
        op_signed    = is_signed_op(funct3_i);
        dividend_neg = op_signed && dividend_i[DATA_WIDTH-1];
        divisor_neg  = op_signed && divisor_i[DATA_WIDTH-1];
        dividend_mag = dividend_neg ? -dividend_i : dividend_i;
        divisor_mag  = divisor_neg  ? -divisor_i  : divisor_i;
    end

    // quot_r doubles as the dividend shift register: its MSB feeds the
    // partial remainder while quotient bits enter at the LSB.
    always_comb begin
        rem_shift = {rem_r, quot_r[DATA_WIDTH-1]};
        rem_diff  = rem_shift - {1'b0, divisor_r};
        if (!rem_diff[DATA_WIDTH]) begin
            rem_next  = rem_diff[DATA_WIDTH-1:0];
            quot_next = {quot_r[DATA_WIDTH-2:0], 1'b1};
        end else begin
            rem_next  = rem_shift[DATA_WIDTH-1:0];
            quot_next = {quot_r[DATA_WIDTH-2:0], 1'b0};
        end
    end

    // On divide-by-zero quot_r holds the raw dividend for the REM/REMU result.
    always_comb begin
        quot_fix = neg_q_r ? -quot_r : quot_r;
        rem_fix  = neg_r_r ? -rem_r  : rem_r;
        if (div0_r) begin
            result_next = rem_sel_r ? quot_r : '1;
        end else begin
            result_next = rem_sel_r ? rem_fix : quot_fix;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= DIV_IDLE;
            counter        <= '0;
            quot_r         <= '0;
            rem_r          <= '0;
            divisor_r      <= '0;
            rd_r           <= '0;
            rem_sel_r      <= 1'b0;
            div0_r         <= 1'b0;
            neg_q_r        <= 1'b0;
            neg_r_r        <= 1'b0;
            result_o       <= '0;
            result_valid_o <= 1'b0;
            rd_addr_o      <= '0;
        end else begin
            result_valid_o <= 1'b0;
            case (state)
                DIV_IDLE: begin
                    if (accept) begin
                        counter   <= '0;
                        rem_r     <= '0;
                        divisor_r <= divisor_mag;
                        rd_r      <= rd_addr_i;
                        rem_sel_r <= is_rem_op(funct3_i);
                        neg_q_r   <= dividend_neg ^ divisor_neg;
                        neg_r_r   <= dividend_neg;
                        if (divisor_i == '0) begin
                            div0_r <= 1'b1;
                            quot_r <= dividend_i;
                            state  <= DIV_DONE;
                        end else begin
                            div0_r <= 1'b0;
                            quot_r <= dividend_mag;
                            state  <= DIV_CALC;
                        end
                    end
                end
                DIV_CALC: begin
                    if (flush_i) begin
                        state <= DIV_IDLE;
                    end else begin
                        rem_r   <= rem_next;
                        quot_r  <= quot_next;
                        counter <= counter + CNT_WIDTH'(1);
                        if (counter == LAST_ITER) begin
                            state <= DIV_DONE;
                        end
                    end
                end
                DIV_DONE: begin
                    if (!flush_i) begin
                        result_o       <= result_next;
                        rd_addr_o      <= rd_r;
                        result_valid_o <= 1'b1;
                    end
                    state <= DIV_IDLE;
                end
                default: state <= DIV_IDLE;
            endcase
        end
    end

endmodule
